// File: rtl/dcache_ctrl.sv
// 2-way set-associative write-back/write-allocate data cache controller (16 sets x 32-byte lines).
// Hit: 0 cycles (combinational data, no stall); miss: 1 + refill wait + 1, plus write-back wait when the victim is dirty.
// Stalls the CPU via cpu_stall_o on a miss; memory requests are held until mem_ack_i; one miss outstanding.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state_q, state_d;

  // Per-way status bits (reset) and per-way tag/data arrays (not reset).
  logic [15:0]  valid_q [2];
  logic [15:0]  dirty_q [2];
  logic [15:0]  lru_q;
  logic [22:0]  tag_q   [2][16];
  logic [255:0] data_q  [2][16];

  // Miss context captured on miss entry and held through write-back/refill.
  logic         miss_way_q;
  logic [3:0]   miss_idx_q;
  logic [22:0]  miss_tag_q;
  logic [22:0]  wb_tag_q;

  logic [22:0]  req_tag;
  logic [3:0]   req_idx;
  logic [7:0]   word_off;
  logic         hit0, hit1, lookup_hit, hit_way;
  logic         cpu_hit, cpu_miss, install;
  logic         victim_way, victim_dirty;
  logic [255:0] hit_line, store_line;
  logic         unused_addr_lsbs;

  assign req_tag          = cpu_addr_i[31:9];
  assign req_idx          = cpu_addr_i[8:5];
  assign word_off         = {cpu_addr_i[4:2], 5'b0};
  assign unused_addr_lsbs = ^cpu_addr_i[1:0];

  assign hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign lookup_hit = hit0 || hit1;
  assign hit_way    = hit1;
  assign hit_line   = data_q[hit_way][req_idx];

  assign cpu_hit  = (state_q == IDLE) && cpu_req_i && lookup_hit;
  assign cpu_miss = (state_q == IDLE) && cpu_req_i && !lookup_hit;
  assign install  = (state_q == REFILL) && mem_ack_i;

  // Victim: first invalid way, else the LRU-named way.
  assign victim_way   = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];

  // Merge the store word into the hit line so the array sees a full-line write.
  always_comb begin
    store_line                 = hit_line;
    store_line[word_off +: 32] = cpu_wdata_i;
  end

  // Next-state and output decode for the miss-handling FSM.
  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        cpu_stall_o = cpu_miss;
        if (cpu_hit) begin
          cpu_rdata_o = hit_line[word_off +: 32];
        end
        if (cpu_miss) begin
          state_d = victim_dirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {wb_tag_q, miss_idx_q, 5'b0};
        mem_wdata_o = data_q[miss_way_q][miss_idx_q];
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {miss_tag_q, miss_idx_q, 5'b0};
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset aborts any memory transaction in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Valid/dirty/LRU bookkeeping: hits update LRU and dirty, fills validate a clean line.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (cpu_hit) begin
        lru_q[req_idx] <= !hit_way;
        if (cpu_write_i) begin
          dirty_q[hit_way][req_idx] <= 1'b1;
        end
      end
      if (install) begin
        valid_q[miss_way_q][miss_idx_q] <= 1'b1;
        dirty_q[miss_way_q][miss_idx_q] <= 1'b0;
      end
    end
  end

  // Tag/data arrays and miss context; no reset, but nothing is written while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (cpu_hit && cpu_write_i) begin
        data_q[hit_way][req_idx] <= store_line;
      end
      if (install) begin
        data_q[miss_way_q][miss_idx_q] <= mem_rdata_i;
        tag_q[miss_way_q][miss_idx_q]  <= miss_tag_q;
      end
      if (cpu_miss) begin
        miss_way_q <= victim_way;
        miss_idx_q <= req_idx;
        miss_tag_q <= req_tag;
        wb_tag_q   <= tag_q[victim_way][req_idx];
      end
    end
  end

endmodule
